// File: rtl/frame_mem_responder.sv
// frame_mem_responder: memory-side responder for the user-logic memory port.
// Maps template/window reads and result writes onto one synchronous SRAM,
// gates the frame with ready_2_start/set_done and lends the SRAM to the host
// for frame load and result readback outside of SERVE.
module frame_mem_responder #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] TEMP_BASE = 16'h0000,
  parameter logic [ADDR_W-1:0] WIN_BASE  = 16'h4000,
  parameter logic [ADDR_W-1:0] RES_BASE  = 16'hC000,
  parameter int                MAX_SETS  = 150
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              rd_wr,
  input  logic              tem_win,
  input  logic [6:0]        row,
  input  logic [6:0]        col,
  input  logic [1:0]        wr_index,
  input  logic [31:0]       write_data,
  input  logic [7:0]        set_count,
  input  logic              set_done,
  output logic [31:0]       read_data,
  output logic              ready_2_start,
  input  logic              frame_start,
  output logic              results_ready,
  input  logic              host_en,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic [31:0]       host_rdata,
  output logic              protocol_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Set numbers are 8 bits wide; compare against the limit with one spare bit.
  localparam logic [8:0] SET_LIMIT = 9'(MAX_SETS);

  state_t            state;
  logic              rd_pend;
  logic              host_pend;
  logic [31:0]       read_hold;
  logic [31:0]       host_hold;

  logic              serve;
  logic              user_rd;
  logic              user_wr;
  logic              host_go;
  logic              illegal;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  // Decode the user request: row*128+col and set*4+index are plain bit concatenations.
  always_comb begin
    serve   = (state == ST_SERVE);
    rd_addr = (tem_win ? WIN_BASE : TEMP_BASE) + ADDR_W'({row, col});
    wr_addr = RES_BASE + ADDR_W'({set_count, wr_index});
    user_rd = serve & req & ~rd_wr;
    user_wr = serve & req & rd_wr & (wr_index != 2'd3) & ({1'b0, set_count} < SET_LIMIT);
    illegal = req & ~user_rd & ~user_wr;
    host_go = ~serve & host_en;
  end

  // Drive the SRAM in the request cycle; user owns it in SERVE, host otherwise.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (user_rd) begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end else if (user_wr) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = write_data;
      end else if (host_go) begin
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_we ? host_wdata : 32'd0;
      end
    end
  end

  // Return data passes straight through in the cycle after a read, then is held.
  always_comb begin
    read_data  = rd_pend ? mem_rdata : read_hold;
    host_rdata = host_pend ? mem_rdata : host_hold;
  end

  // Frame FSM with registered status flags, read tracking and the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_LOAD;
      ready_2_start <= 1'b0;
      results_ready <= 1'b0;
      protocol_err  <= 1'b0;
      rd_pend       <= 1'b0;
      host_pend     <= 1'b0;
      read_hold     <= '0;
      host_hold     <= '0;
    end else begin
      rd_pend   <= user_rd;
      host_pend <= host_go & ~host_we;
      if (rd_pend) begin
        read_hold <= mem_rdata;
      end
      if (host_pend) begin
        host_hold <= mem_rdata;
      end
      if (illegal) begin
        protocol_err <= 1'b1;
      end else if (frame_start) begin
        protocol_err <= 1'b0;
      end
      case (state)
        ST_LOAD: begin
          if (frame_start) begin
            state         <= ST_SERVE;
            ready_2_start <= 1'b1;
            results_ready <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (set_done) begin
            state         <= ST_DONE;
            ready_2_start <= 1'b0;
            results_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          if (frame_start) begin
            state         <= ST_SERVE;
            ready_2_start <= 1'b1;
            results_ready <= 1'b0;
          end
        end
        default: begin
          state         <= ST_LOAD;
          ready_2_start <= 1'b0;
          results_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_mem_responder.sv
// tb_frame_mem_responder: directed frame scenarios followed by randomized
// traffic, every cycle compared against a behavioural model of the responder.
module tb_frame_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        rd_wr;
  logic        tem_win;
  logic [6:0]  row;
  logic [6:0]  col;
  logic [1:0]  wr_index;
  logic [31:0] write_data;
  logic [7:0]  set_count;
  logic        set_done;
  logic [31:0] read_data;
  logic        ready_2_start;
  logic        frame_start;
  logic        results_ready;
  logic        host_en;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        protocol_err;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  int n_checks = 0;
  int n_bad    = 0;

  // Model: 0 = loading, 1 = serving, 2 = results ready.
  int          m_state;
  logic [31:0] m_rd;
  logic [31:0] m_hrd;
  logic        m_perr;
  logic [31:0] shadow [logic [15:0]];
  logic [31:0] sram   [logic [15:0]];

  always #5 clk = ~clk;

  frame_mem_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .rd_wr         (rd_wr),
    .tem_win       (tem_win),
    .row           (row),
    .col           (col),
    .wr_index      (wr_index),
    .write_data    (write_data),
    .set_count     (set_count),
    .set_done      (set_done),
    .read_data     (read_data),
    .ready_2_start (ready_2_start),
    .frame_start   (frame_start),
    .results_ready (results_ready),
    .host_en       (host_en),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .protocol_err  (protocol_err),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  // Unwritten words return a pattern derived from their address.
  function automatic logic [31:0] fill_val(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Synchronous SRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        sram[mem_addr] = mem_wdata;
      end else begin
        mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : fill_val(mem_addr);
      end
    end
  end

  function automatic logic [31:0] shadow_val(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : fill_val(a);
  endfunction

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req = 0; rd_wr = 0; tem_win = 0; row = 0; col = 0; wr_index = 0;
    write_data = 0; set_count = 0; set_done = 0; frame_start = 0;
    host_en = 0; host_we = 0; host_addr = 0; host_wdata = 0;
  endtask

  // Called just after a falling edge with inputs set; checks, advances the model, waits one cycle.
  task automatic run_cycle();
    logic        e_en, e_we, rd_hit, hr_hit, bad;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    int          a;
    #1;
    e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0; rd_hit = 0; hr_hit = 0; bad = 0;
    if (req) begin
      if (m_state == 1 && !rd_wr) begin
        a = (tem_win ? 'h4000 : 0) + int'(row) * 128 + int'(col);
        e_en = 1; rd_hit = 1; e_addr = 16'(a);
      end else if (m_state == 1 && wr_index != 2'd3 && int'(set_count) < 150) begin
        a = 'hC000 + int'(set_count) * 4 + int'(wr_index);
        e_en = 1; e_we = 1; e_addr = 16'(a); e_wdata = write_data;
      end else begin
        bad = 1;
      end
    end
    if (m_state != 1 && host_en) begin
      e_en = 1; e_we = host_we; e_addr = host_addr; e_wdata = host_wdata; hr_hit = !host_we;
    end
    checkOutput("mem_en", mem_en, e_en);
    if (e_en) begin
      checkOutput("mem_we", mem_we, e_we);
      checkOutput("mem_addr", mem_addr, e_addr);
      if (e_we) checkOutput("mem_wdata", mem_wdata, e_wdata);
    end
    checkOutput("read_data", read_data, m_rd);
    checkOutput("host_rdata", host_rdata, m_hrd);
    checkOutput("ready_2_start", ready_2_start, m_state == 1);
    checkOutput("results_ready", results_ready, m_state == 2);
    checkOutput("protocol_err", protocol_err, m_perr);
    if (e_en && e_we) shadow[e_addr] = e_wdata;
    if (rd_hit) m_rd = shadow_val(e_addr);
    if (hr_hit) m_hrd = shadow_val(e_addr);
    if (frame_start) m_perr = 0;
    if (bad) m_perr = 1;
    if (m_state == 1) begin
      if (set_done) m_state = 2;
    end else if (frame_start) begin
      m_state = 1;
    end
    @(negedge clk);
  endtask

  // Assert reset at a falling edge, verify outputs clear at once, release a cycle later.
  task automatic applyReset();
    clear_inputs();
    rst_n = 0;
    #1;
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_read_data", read_data, 0);
    checkOutput("rst_host_rdata", host_rdata, 0);
    checkOutput("rst_ready_2_start", ready_2_start, 0);
    checkOutput("rst_results_ready", results_ready, 0);
    checkOutput("rst_protocol_err", protocol_err, 0);
    m_state = 0; m_rd = 0; m_hrd = 0; m_perr = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Randomized inputs shaped by the model's current frame phase.
  task automatic applyStimulus();
    clear_inputs();
    if (m_state == 1) begin
      req        = ($urandom_range(0, 99) < 70);
      rd_wr      = 1'($urandom_range(0, 1));
      tem_win    = 1'($urandom_range(0, 1));
      row        = 7'($urandom_range(0, 127));
      col        = 7'($urandom_range(0, 127));
      wr_index   = rd_wr ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
      set_count  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(140, 255))
                                               : 8'($urandom_range(0, 149));
      write_data = $urandom;
      set_done   = ($urandom_range(0, 49) == 0);
      host_en    = 1'($urandom_range(0, 1));
      host_we    = 1'($urandom_range(0, 1));
      host_addr  = 16'($urandom);
      host_wdata = $urandom;
    end else if ($urandom_range(0, 19) == 0) begin
      req   = 1;
      rd_wr = 1'($urandom_range(0, 1));
      row   = 7'($urandom_range(0, 127));
    end else begin
      host_en    = ($urandom_range(0, 99) < 60);
      host_we    = 1'($urandom_range(0, 1));
      host_wdata = $urandom;
      case ($urandom_range(0, 2))
        0:       host_addr = 16'h4185;
        1:       host_addr = 16'(32'hC000 + $urandom_range(0, 599));
        default: host_addr = 16'($urandom);
      endcase
      frame_start = ($urandom_range(0, 14) == 0);
    end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    m_state = 0; m_rd = 0; m_hrd = 0; m_perr = 0;
    @(negedge clk);
    applyReset();

    // Host loads a window word, then the frame starts and the user reads it back.
    host_en = 1; host_we = 1; host_addr = 16'h4185; host_wdata = 32'hDEADBEEF;
    run_cycle();
    clear_inputs(); frame_start = 1; run_cycle();
    clear_inputs(); req = 1; tem_win = 1; row = 3; col = 5; run_cycle();
    clear_inputs(); run_cycle();
    checkOutput("held_read_data", read_data, 32'hDEADBEEF);

    // Result write, then two illegal writes.
    clear_inputs(); req = 1; rd_wr = 1; set_count = 2; wr_index = 1; write_data = 32'h12345678;
    run_cycle();
    clear_inputs(); req = 1; rd_wr = 1; set_count = 0; wr_index = 3; run_cycle();
    clear_inputs(); req = 1; rd_wr = 1; set_count = 150; wr_index = 0; run_cycle();
    clear_inputs(); run_cycle();

    // set_done together with a read, then host readback of the result.
    clear_inputs(); req = 1; tem_win = 1; row = 3; col = 5; set_done = 1; run_cycle();
    clear_inputs(); run_cycle();
    clear_inputs(); host_en = 1; host_addr = 16'hC009; run_cycle();
    clear_inputs(); run_cycle();
    checkOutput("held_host_rdata", host_rdata, 32'h12345678);

    // New frame clears the error; a read in flight is dropped by reset.
    clear_inputs(); frame_start = 1; run_cycle();
    clear_inputs(); req = 1; row = 1; col = 2; run_cycle();
    applyReset();
    clear_inputs(); run_cycle();

    // A read while loading is refused and flagged until the next frame_start.
    clear_inputs(); req = 1; row = 4; run_cycle();
    clear_inputs(); run_cycle();
    clear_inputs(); frame_start = 1; run_cycle();
    clear_inputs(); run_cycle();

    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
